// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave word receiver.
// State encoding and bus error classification codes.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARM       = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_HIGH      = 2'd3
    } rd_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_STOP  = 2'b10;

endpackage

// File: rtl/i2c_input_filter.sv
// Two-flop synchroniser followed by a persistence filter.
// The filtered line only follows after FILTER_LEN stable samples.
module i2c_input_filter #(
    parameter int FILTER_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o
);

    logic s1_q;
    logic s2_q;

    // Synchronise the raw pad into the clock domain; idle bus is high
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= line_i;
            s2_q <= s1_q;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign line_o = s2_q;
        end else begin : g_filt
            localparam int CW = $clog2(FILTER_LEN + 1);
            logic [CW-1:0] cnt_q;
            logic          filt_q;

            // Count consecutive samples differing from the filtered level
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (s2_q == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    cnt_q  <= '0;
                    filt_q <= s2_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign line_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/i2c_slave_read_word.sv
// I2C slave receive engine: shifts in one word per enable window.
// Bits sampled on SCL rise, counted on SCL fall; START/STOP abort.
module i2c_slave_read_word
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FILTER_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  read_err,
    output logic [1:0]            read_err_code,
    output logic                  read_busy,
    input  logic                  scl_i,
    input  logic                  sda_i
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic                  scl_f;
    logic                  sda_f;
    logic                  scl_d_q;
    logic                  sda_d_q;
    rd_state_e             state_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH:0]   shift_ext;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  err_q;
    logic [1:0]            code_q;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  sda_chg;

    i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (scl_i),
        .line_o (scl_f)
    );

    i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (sda_i),
        .line_o (sda_f)
    );

    // One-cycle delayed copies of the filtered lines for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d_q <= 1'b1;
            sda_d_q <= 1'b1;
        end else begin
            scl_d_q <= scl_f;
            sda_d_q <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_d_q;
    assign scl_fall = ~scl_f & scl_d_q;
    assign sda_chg  = sda_f ^ sda_d_q;
    assign cnt_inc  = cnt_q + CW'(1);

    // Insert the new bit at the end that moves toward its final position
    always_comb begin
        shift_ext = '0;
        shift_d   = shift_q;
        if (MSB_FIRST) begin
            shift_ext = {shift_q, sda_f};
            shift_d   = shift_ext[DATA_WIDTH-1:0];
        end else begin
            shift_ext = {sda_f, shift_q};
            shift_d   = shift_ext[DATA_WIDTH:1];
        end
    end

    // Receive FSM with registered data, pulses and error code
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (state_q != ST_IDLE && !read_en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                shift_q <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        cnt_q   <= '0;
                        shift_q <= '0;
                        if (read_en)
                            state_q <= scl_f ? ST_ARM : ST_WAIT_RISE;
                    end
                    ST_ARM: begin
                        if (scl_fall)
                            state_q <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            state_q <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (scl_fall) begin
                            state_q <= ST_WAIT_RISE;
                            if (cnt_inc == CW'(DATA_WIDTH)) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else if (sda_chg && scl_f && scl_d_q) begin
                            err_q   <= 1'b1;
                            code_q  <= sda_f ? ERR_STOP : ERR_START;
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            shift_q <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign read_data     = data_q;
    assign read_valid    = valid_q;
    assign read_err      = err_q;
    assign read_err_code = code_q;
    assign read_busy     = (state_q != ST_IDLE);

endmodule
